// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register width,
// NOP encoding used by the D->EX bubble, and the memory-wait FSM states.
package pipe_hazard_ctrl_pkg;

    localparam int          REG_BITS = 5;
    localparam logic [31:0] NOP_INSN = 32'h2000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_BITS = pipe_hazard_ctrl_pkg::REG_BITS
);

    logic [REG_BITS-1:0] D_rs1;
    logic [REG_BITS-1:0] D_rs2;
    logic                D_use_rs1;
    logic                D_use_rs2;
    logic [REG_BITS-1:0] EX_rd;
    logic                EX_is_load;
    logic                EX_taken;
    logic                MEM_req;
    logic                MEM_ready;

    logic                stall_F;
    logic                stall_D;
    logic                bubble_EX;
    logic                flush_D;
    logic                stall_EX;

    modport master (
        output D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_is_load, EX_taken,
               MEM_req, MEM_ready,
        input  stall_F, stall_D, bubble_EX, flush_D, stall_EX
    );

    modport slave (
        input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_is_load, EX_taken,
               MEM_req, MEM_ready,
        output stall_F, stall_D, bubble_EX, flush_D, stall_EX
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics; holds at all-ones.
module sat_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_BITS{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock,
// mispredict flush, data-memory wait with sticky timeout, perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS    = pipe_hazard_ctrl_pkg::REG_BITS,
    parameter int CNT_BITS    = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz,
    output logic                mem_timeout,
    output logic [CNT_BITS-1:0] stall_cycles,
    output logic [CNT_BITS-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    function automatic logic [WCNT_W-1:0] wait_inc(input logic [WCNT_W-1:0] v);
        return (v == WCNT_W'(MEM_TIMEOUT)) ? v : v + 1'b1;
    endfunction

    logic [REG_BITS-1:0] d_rs1, d_rs2, ex_rd;
    logic                mem_wait, load_use;
    logic                stall_f, stall_d, bubble_ex, flush_d, stall_ex;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    assign d_rs1 = hz.D_rs1;
    assign d_rs2 = hz.D_rs2;
    assign ex_rd = hz.EX_rd;

    // Priority: memory wait freezes everything, then redirect, then load-use.
    always_comb begin
        mem_wait  = hz.MEM_req & ~hz.MEM_ready;
        load_use  = hz.EX_is_load && (ex_rd != '0) &&
                    ((hz.D_use_rs1 && (d_rs1 == ex_rd)) ||
                     (hz.D_use_rs2 && (d_rs2 == ex_rd)));
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        bubble_ex = 1'b0;
        flush_d   = 1'b0;
        stall_ex  = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (mem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_ex = 1'b1;
        end else if (hz.EX_taken) begin
            flush_d   = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // wait_cnt counts completed wait cycles, so the first wait cycle leaves it at 1.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = wait_inc('0);
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    wait_cnt_d = wait_inc(wait_cnt_q);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (mem_wait && (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (flush_count)
    );

    assign hz.stall_F   = stall_f;
    assign hz.stall_D   = stall_d;
    assign hz.bubble_EX = bubble_ex;
    assign hz.flush_D   = flush_d;
    assign hz.stall_EX  = stall_ex;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and 2-bit
// counters so saturation and the sticky timeout are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int RB = 5;
    localparam int CB = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_timeout;
    logic [CB-1:0] stall_cycles;
    logic [CB-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if #(.REG_BITS(RB)) hz ();

    pipe_hazard_ctrl #(.REG_BITS(RB), .CNT_BITS(CB), .MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed {stall_F, stall_D, bubble_EX, flush_D, stall_EX}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, hz.stall_F, hz.stall_D, hz.bubble_EX, hz.flush_D, hz.stall_EX},
            {27'd0, exp});
    endtask

    task automatic idle();
        hz.D_rs1 = '0; hz.D_rs2 = '0; hz.D_use_rs1 = 1'b0; hz.D_use_rs2 = 1'b0;
        hz.EX_rd = '0; hz.EX_is_load = 1'b0; hz.EX_taken = 1'b0;
        hz.MEM_req = 1'b0; hz.MEM_ready = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        // Reset with hazards present: outputs forced low
        hz.MEM_req = 1'b1; hz.EX_is_load = 1'b1; hz.EX_rd = 5'd5;
        hz.D_use_rs1 = 1'b1; hz.D_rs1 = 5'd5;
        #1;
        chk_ctl("rst_ctl", 5'b00000);
        step();
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_flush_cnt", 32'(flush_count), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk_ctl("idle_ctl", 5'b00000);

        // Load-use on rs1
        hz.EX_is_load = 1'b1; hz.EX_rd = 5'd5; hz.D_use_rs1 = 1'b1; hz.D_rs1 = 5'd5;
        #1;
        chk_ctl("lu_rs1", 5'b11100);
        step();
        idle();
        #1;
        chk_ctl("lu_clear", 5'b00000);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // Load-use on rs2
        hz.EX_is_load = 1'b1; hz.EX_rd = 5'd7; hz.D_use_rs2 = 1'b1; hz.D_rs2 = 5'd7;
        hz.D_rs1 = 5'd3; hz.D_use_rs1 = 1'b1;
        #1;
        chk_ctl("lu_rs2", 5'b11100);
        step();
        idle();

        // No hazard: rd=0, unused source, non-load, mismatched reg
        hz.EX_is_load = 1'b1; hz.EX_rd = 5'd0; hz.D_use_rs1 = 1'b1; hz.D_rs1 = 5'd0;
        #1;
        chk_ctl("nh_rd0", 5'b00000);
        hz.EX_rd = 5'd5; hz.D_rs1 = 5'd5; hz.D_use_rs1 = 1'b0;
        #1;
        chk_ctl("nh_nouse", 5'b00000);
        hz.D_use_rs1 = 1'b1; hz.EX_is_load = 1'b0;
        #1;
        chk_ctl("nh_noload", 5'b00000);
        hz.EX_is_load = 1'b1; hz.D_rs1 = 5'd6;
        #1;
        chk_ctl("nh_diff", 5'b00000);
        step();
        idle();
        #1;
        chk("nh_stall_cnt", 32'(stall_cycles), 32'd2);

        // Flush beats load-use
        do_reset();
        hz.EX_is_load = 1'b1; hz.EX_rd = 5'd5; hz.D_use_rs1 = 1'b1; hz.D_rs1 = 5'd5;
        hz.EX_taken = 1'b1;
        #1;
        chk_ctl("flush_lu", 5'b00110);
        step();
        idle();
        #1;
        chk("flush_cnt", 32'(flush_count), 32'd1);
        chk("flush_stall_cnt", 32'(stall_cycles), 32'd0);

        // Memory wait 3 cycles, redirect ignored, ready on 4th
        do_reset();
        hz.MEM_req = 1'b1; hz.MEM_ready = 1'b0;
        #1;
        chk_ctl("mw_c1", 5'b11001);
        step();
        hz.EX_taken = 1'b1;
        #1;
        chk_ctl("mw_c2_taken", 5'b11001);
        step();
        hz.EX_taken = 1'b0;
        #1;
        chk_ctl("mw_c3", 5'b11001);
        step();
        hz.MEM_ready = 1'b1;
        #1;
        chk_ctl("mw_ready", 5'b00000);
        step();
        idle();
        #1;
        chk("mw_stall_cnt", 32'(stall_cycles), 32'd3);
        chk("mw_flush_cnt", 32'(flush_count), 32'd0);
        chk("mw_no_timeout", 32'(mem_timeout), 32'd0);

        // Zero-wait access
        hz.MEM_req = 1'b1; hz.MEM_ready = 1'b1;
        #1;
        chk_ctl("zero_wait", 5'b00000);
        step();
        idle();

        // Timeout after 4 wait cycles, sticky through ready, cleared by rst
        do_reset();
        hz.MEM_req = 1'b1; hz.MEM_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk($sformatf("to_c%0d", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
            chk_ctl($sformatf("to_ctl%0d", i), 5'b11001);
            step();
        end
        hz.MEM_ready = 1'b1;
        #1;
        chk_ctl("to_ready", 5'b00000);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        step();
        idle();
        #1;
        chk("to_sticky2", 32'(mem_timeout), 32'd1);
        chk("sat_stall_cnt", 32'(stall_cycles), 32'd3);
        do_reset();
        #1;
        chk("to_rst_clear", 32'(mem_timeout), 32'd0);

        // Counter saturation at 2 bits, then rst mid-wait
        hz.MEM_req = 1'b1; hz.MEM_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("sat5_stall_cnt", 32'(stall_cycles), 32'd3);
        rst = 1'b1;
        #1;
        chk_ctl("rst_mid_wait", 5'b00000);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rmw_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rmw_timeout", 32'(mem_timeout), 32'd0);

        // Fresh wait of 3 cycles must not time out if wait count restarted
        hz.MEM_req = 1'b1; hz.MEM_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        hz.MEM_ready = 1'b1;
        #1;
        chk_ctl("rmw_ready", 5'b00000);
        step();
        idle();
        #1;
        chk("rmw_no_timeout", 32'(mem_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
